mips_memory: RTL and testbench

//  - Unified word-addressed data/instruction memory for the multicycle MIPS datapath.
//  - Sits between the datapath (address from PC/ALUOut mux, write data from register B) and the memory data register.
//  - Synchronous write, combinational read by default. Read data is gated by MemRead.

---
 rtl/mips_mem_pkg.sv | 11 +
 rtl/mips_memory.sv | 64 ++++++
 tb/tb_mips_memory.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared sizing and types for the multicycle MIPS unified memory.
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mips_memory.sv
// Unified word-addressed data/instruction memory for the multicycle MIPS.
// Define MIPS_MEM_REG_OUT_EN for a registered (1-cycle) read port.
module mips_memory #(
    parameter int DATA_W = mips_mem_pkg::DATA_W,
    parameter int ADDR_W = mips_mem_pkg::ADDR_W,
    parameter int DEPTH  = mips_mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] MemData
);
    import mips_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data_d;

    // Upper address bits alias onto the low words by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[ADDR_W-1:IDX_W];

    assign idx = Address[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite) begin
            mem_q[idx] <= WriteData;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (MemRead) begin
            rd_data_d = mem_q[idx];
        end
    end

`ifdef MIPS_MEM_REG_OUT_EN
    logic [DATA_W-1:0] rd_data_q;

    // Samples the pre-edge word, so same-index read+write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign MemData = rd_data_q;
`else
    assign MemData = rd_data_d;
`endif

endmodule

// File: tb/tb_mips_memory.sv
// Self-checking bench for mips_memory (combinational or registered read).
module tb_mips_memory;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];
    string       name_q[$];
    vec_t        vecs[$];

    mips_memory dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WriteData(WriteData),
        .MemData  (MemData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one vector at negedge; the expected read value is the
    // pre-edge contents, visible now (comb) or after the edge (reg).
    task automatic step(input vec_t v);
        logic [31:0] e;
        string       nm;
        @(negedge clk);
        MemWrite  = v.we;
        MemRead   = v.re;
        Address   = v.addr;
        WriteData = v.wdata;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
`ifdef MIPS_MEM_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, MemData, e);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e, input string nm);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d;
        v.exp = e; v.name = nm;
        return v;
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;

        vecs.push_back(mk(0, 1, 32'd0,   32'h0, 32'h0, "rst_a0"));
        vecs.push_back(mk(0, 1, 32'd5,   32'h0, 32'h0, "rst_a5"));
        vecs.push_back(mk(0, 1, 32'd10,  32'h0, 32'h0, "rst_a10"));
        vecs.push_back(mk(0, 1, 32'd255, 32'h0, 32'h0, "rst_a255"));
        vecs.push_back(mk(1, 0, 32'd10,  32'hAAAAAAAA, 32'h0, "wr10_nord"));
        vecs.push_back(mk(0, 1, 32'd5,   32'h0, 32'h0, "rd5"));
        vecs.push_back(mk(0, 1, 32'd10,  32'h0, 32'hAAAAAAAA, "rd10"));
        vecs.push_back(mk(0, 0, 32'd10,  32'h0, 32'h0, "gate_rd"));
        vecs.push_back(mk(0, 1, 32'd10,  32'h55555555, 32'hAAAAAAAA, "gate_wr"));
        vecs.push_back(mk(0, 1, 32'd10,  32'h0, 32'hAAAAAAAA, "rd10_keep"));
        vecs.push_back(mk(1, 0, 32'd259, 32'h12345678, 32'h0, "wr_wrap"));
        vecs.push_back(mk(0, 1, 32'd3,   32'h0, 32'h12345678, "rd_wrap3"));
        vecs.push_back(mk(0, 1, 32'd259, 32'h0, 32'h12345678, "rd_wrap259"));
        vecs.push_back(mk(1, 0, 32'd7,   32'h1, 32'h0, "wr7_1"));
        vecs.push_back(mk(1, 1, 32'd7,   32'h2, 32'h1, "rw7_old"));
        vecs.push_back(mk(0, 1, 32'd7,   32'h0, 32'h2, "rd7_new"));
        vecs.push_back(mk(1, 1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, "rw_top"));
        vecs.push_back(mk(0, 1, 32'd255, 32'h0, 32'hDEADBEEF, "rd255"));
        vecs.push_back(mk(0, 1, 32'd0,   32'h0, 32'h0, "rd0_clean"));

        // Reset held: output must be 0.
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", MemData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Async reset between edges while a write is pending.
        @(negedge clk);
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        Address   = 32'd20;
        WriteData = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", MemData, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_out", MemData, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n    = 1'b1;

        step(mk(0, 1, 32'd20,  32'h0, 32'h0, "post_rst20"));
        step(mk(0, 1, 32'd10,  32'h0, 32'h0, "post_rst10"));
        step(mk(0, 1, 32'd3,   32'h0, 32'h0, "post_rst3"));
        step(mk(0, 1, 32'd7,   32'h0, 32'h0, "post_rst7"));
        step(mk(0, 1, 32'd255, 32'h0, 32'h0, "post_rst255"));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
